// File: rtl/alu.sv
// 32-bit MIPS-style ALU with registered result and zero/carry/overflow flags.
// Optional shift ops (SLL/SRL/SRA on b[4:0]) are enabled by defining ALU_SHIFT_EN.
module alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] res,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_XNOR = 4'b1100;
`ifdef ALU_SHIFT_EN
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
`endif

   logic               is_sub;
   logic [WIDTH-1:0]   b_op;
   logic [WIDTH:0]     sum_ext;
   logic               sum_ovf;

   logic [WIDTH-1:0]   res_d, res_q;
   logic               zero_d, zero_q;
   logic               carry_d, carry_q;
   logic               ovf_d, ovf_q;

   // One shared adder: SUB and SLT both use a + ~b + 1.
   always_comb begin
      is_sub  = (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT);
      b_op    = is_sub ? ~b : b;
      sum_ext = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
      sum_ovf = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
   end

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      case (alu_ctrl)
         OP_AND:  res_d = a & b;
         OP_OR:   res_d = a | b;
         OP_XNOR: res_d = ~(a ^ b);
         OP_ADD, OP_SUB: begin
            res_d   = sum_ext[WIDTH-1:0];
            carry_d = sum_ext[WIDTH];
            ovf_d   = sum_ovf;
         end
         // Sign of a-b corrected by overflow gives the true signed compare.
         OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, sum_ext[WIDTH-1] ^ sum_ovf};
`ifdef ALU_SHIFT_EN
         OP_SLL:  res_d = a << b[4:0];
         OP_SRL:  res_d = a >> b[4:0];
         OP_SRA:  res_d = $signed(a) >>> b[4:0];
`endif
         default: res_d = '0;
      endcase
      zero_d = (res_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q   <= '0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
      end
   end

   assign res       = res_q;
   assign zero      = zero_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random ops against an arithmetic reference model.
module tb_alu;

   logic        clk;
   logic        rst_n;
   logic [31:0] a, b;
   logic [3:0]  alu_ctrl;
   logic [31:0] res;
   logic        zero, carry_out, overflow;

   int errors = 0;
   int checks = 0;

   alu #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .alu_ctrl(alu_ctrl),
      .res(res), .zero(zero), .carry_out(carry_out), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference computed from signed/unsigned integer arithmetic at 64 bits.
   function automatic void model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                 output logic [31:0] r, output logic c, output logic v);
      longint sa, sb, ua, ub, t;
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      ua = longint'({32'd0, av});
      ub = longint'({32'd0, bv});
      r = 32'd0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0:  r = av & bv;
         4'd1:  r = av | bv;
         4'd2: begin
            t = sa + sb;
            r = t[31:0];
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            c = (ua + ub) >= 64'sd4294967296;
         end
         4'd6: begin
            t = sa - sb;
            r = t[31:0];
            v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            c = (ua >= ub);
         end
         4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd12: r = ~(av ^ bv);
`ifdef ALU_SHIFT_EN
         4'd8: begin t = ua << bv[4:0]; r = t[31:0]; end
         4'd9: begin t = ua >> bv[4:0]; r = t[31:0]; end
         4'd10: begin t = sa >>> bv[4:0]; r = t[31:0]; end
`endif
         default: r = 32'd0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [31:0] er, input logic ez,
                             input logic ec, input logic ev);
      check({tag, ".res"},   res,                {31'd0, 1'b0} | er);
      check({tag, ".zero"},  {31'd0, zero},      {31'd0, ez});
      check({tag, ".carry"}, {31'd0, carry_out}, {31'd0, ec});
      check({tag, ".ovf"},   {31'd0, overflow},  {31'd0, ev});
   endtask

   // Apply one op, compare against the model; optionally against a literal expected result too.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                         input logic [31:0] bv, input bit has_exp, input logic [31:0] exp_res);
      logic [31:0] er;
      logic ec, ev;
      @(negedge clk);
      alu_ctrl = op; a = av; b = bv;
      model(op, av, bv, er, ec, ev);
      @(posedge clk);
      #1;
      check_outs(tag, er, (er == 32'd0), ec, ev);
      if (has_exp) check({tag, ".lit"}, res, exp_res);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      rst_n = 1'b1; a = '0; b = '0; alu_ctrl = 4'd0;

      // Asynchronous reset, no clock edge yet
      #2 rst_n = 1'b0;
      #1 check_outs("rst_async", 32'd0, 1'b1, 1'b0, 1'b0);
      a = 32'd7; b = 32'd9; alu_ctrl = 4'd2;
      repeat (2) @(posedge clk);
      #1 check_outs("rst_hold", 32'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk) rst_n = 1'b1;

      run_op("and_neg", 4'd0, -20, 10, 1'b1, 32'd8);
      check("and_neg.zero_lit", {31'd0, zero}, 32'd0);
      run_op("or",     4'd1, 10, 40, 1'b1, 32'd42);
      run_op("and",    4'd0, 7, 5, 1'b1, 32'd5);
      run_op("xnor",   4'd12, 0, 4750, 1'b1, -4751);
      run_op("add",    4'd2, 32768, 512, 1'b1, 32'd33280);
      run_op("add_ov", 4'd2, 32'h7FFF_FFFF, 1, 1'b1, 32'h8000_0000);
      check("add_ov.ovf_lit", {31'd0, overflow}, 32'd1);
      check("add_ov.carry_lit", {31'd0, carry_out}, 32'd0);
      run_op("sub_ov", 4'd6, 32'h8000_0000, 1, 1'b1, 32'h7FFF_FFFF);
      check("sub_ov.ovf_lit", {31'd0, overflow}, 32'd1);
      check("sub_ov.carry_lit", {31'd0, carry_out}, 32'd1);
      run_op("add_zero", 4'd2, 32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 32'd0);
      check("add_zero.zero_lit", {31'd0, zero}, 32'd1);
      check("add_zero.carry_lit", {31'd0, carry_out}, 32'd1);
      run_op("sub_zero", 4'd6, -50, -50, 1'b1, 32'd0);
      check("sub_zero.zero_lit", {31'd0, zero}, 32'd1);
      run_op("slt1", 4'd7, -10, 20, 1'b1, 32'd1);
      run_op("slt2", 4'd7, 10, 12, 1'b1, 32'd1);
      run_op("slt3", 4'd7, 12, 10, 1'b1, 32'd0);
      run_op("slt4", 4'd7, -12, -14, 1'b1, 32'd0);
      check("slt4.zero_lit", {31'd0, zero}, 32'd1);
      run_op("slt_ov", 4'd7, 32'h8000_0000, 1, 1'b1, 32'd1);
      run_op("slt_ov2", 4'd7, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'd0);
      run_op("undef", 4'd3, 5, 3, 1'b1, 32'd0);
      check("undef.zero_lit", {31'd0, zero}, 32'd1);
`ifdef ALU_SHIFT_EN
      run_op("sra", 4'd10, -16, 2, 1'b1, -4);
      run_op("sll", 4'd8, 1, 31, 1'b1, 32'h8000_0000);
      run_op("srl", 4'd9, 32'h8000_0000, 31, 1'b1, 32'd1);
`else
      run_op("sll_off", 4'd8, 1, 31, 1'b1, 32'd0);
      run_op("sra_off", 4'd10, -16, 2, 1'b1, 32'd0);
`endif

      // Reset asserted mid-operation discards the pending result
      @(negedge clk);
      alu_ctrl = 4'd2; a = 32'd5; b = 32'd6;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1 check_outs("rst_mid", 32'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      #1 check_outs("rst_rel", 32'd0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1 check("rst_first.res", res, 32'd11);

      // Random ops, with corner operands mixed in
      for (int i = 0; i < 300; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h8000_0000;
            1: rb = 32'h7FFF_FFFF;
            2: rb = ra;
            default: ;
         endcase
         run_op("rand", rop, ra, rb, 1'b0, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
